// File: rtl/exp5_unidade_controle.sv
// exp5_unidade_controle: Moore control unit for the Experiment 5 memory-game datapath.
//
// It steps the address counter and the play register through one 16-position round.
// It then reports whether the player hit every position or missed one.
//
// Optional feature (macro EXP5_UC_TIMEOUT_EN): a wait counter in espera_jogada.
// If no play arrives within TIMEOUT_CYCLES cycles, the round ends in fim_timeout.
// Without the macro no counter exists, fim_timeout is unreachable and timeout is constant 0.
//
// Ports:
//   clock        system clock, rising edge active
//   reset        asynchronous active-low reset, forces state inicial
//   iniciar      start request (acted on in inicial and in the end states only)
//   jogada_feita one-cycle play pulse from the datapath edge detector
//   igual        memory data equals registered play
//   fimC         address counter at its last position
//   zeraC        clear address counter
//   contaC       increment address counter
//   zeraR        clear play register
//   registraR    load play register
//   pronto       round finished (any end state)
//   acertou      round finished with every play correct
//   errou        round finished on a wrong play
//   timeout      round finished by timeout
//   db_estado    current state code for the debug display
module exp5_unidade_controle #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // Encodings double as the debug display codes.
  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPreparacao   = 4'h1,
    StEsperaJogada = 4'h2,
    StRegistra     = 4'h4,
    StComparacao   = 4'h5,
    StProximo      = 4'h6,
    StFimAcertou   = 4'hA,
    StFimTimeout   = 4'hD,
    StFimErrou     = 4'hE
  } state_e;

  state_e state_q, state_d;

`ifdef EXP5_UC_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired;

  // Held at zero outside espera_jogada, so every entry starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == StEsperaJogada) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state from state and inputs; outputs decoded from state only.
  always_comb begin
    state_d   = state_q;
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      StInicial: begin
        if (iniciar) state_d = StPreparacao;
      end
      StPreparacao: begin
        zeraC   = 1'b1;
        zeraR   = 1'b1;
        state_d = StEsperaJogada;
      end
      StEsperaJogada: begin
        // A play in the final cycle takes priority over the timeout.
        if (jogada_feita) begin
          state_d = StRegistra;
        end
`ifdef EXP5_UC_TIMEOUT_EN
        else if (expired) begin
          state_d = StFimTimeout;
        end
`endif
      end
      StRegistra: begin
        registraR = 1'b1;
        state_d   = StComparacao;
      end
      StComparacao: begin
        if (!igual) begin
          state_d = StFimErrou;
        end else if (fimC) begin
          state_d = StFimAcertou;
        end else begin
          state_d = StProximo;
        end
      end
      StProximo: begin
        contaC  = 1'b1;
        state_d = StEsperaJogada;
      end
      StFimAcertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
      StFimErrou: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
`ifdef EXP5_UC_TIMEOUT_EN
      StFimTimeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
`endif
      default: begin
        state_d = StInicial;
      end
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
module tb_exp5_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada_feita;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;
  int reg_cnt  = 0;
  int conta_cnt = 0;

  always #5 clock = ~clock;

  exp5_unidade_controle #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .jogada_feita(jogada_feita),
    .igual       (igual),
    .fimC        (fimC),
    .zeraC       (zeraC),
    .contaC      (contaC),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .timeout     (timeout),
    .db_estado   (db_estado)
  );

  // Every state lasts whole cycles, so one sample per negedge counts pulses.
  always @(negedge clock) begin
    if (registraR === 1'b1) reg_cnt <= reg_cnt + 1;
    if (contaC === 1'b1) conta_cnt <= conta_cnt + 1;
  end

  // Observed outputs: {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [11:0] obs();
    return {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
  endfunction

  // Expected outputs for a state code, straight from the state behaviour table.
  function automatic logic [11:0] expv(input logic [3:0] code);
    logic [7:0] f;
    case (code)
      4'h1:    f = 8'b1010_0000;
      4'h4:    f = 8'b0001_0000;
      4'h6:    f = 8'b0100_0000;
      4'hA:    f = 8'b0000_1100;
      4'hE:    f = 8'b0000_1010;
      4'hD:    f = 8'b0000_1001;
      default: f = 8'b0000_0000;
    endcase
    return {code, f};
  endfunction

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs() !== expv(4'h0)) begin
      failures++; $display("FAIL reset_held got=%h want=%h", obs(), expv(4'h0));
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      jogada_feita = 1'($urandom); igual = 1'($urandom); fimC = 1'($urandom);
      @(negedge clock);
      checks++;
      if (obs() !== expv(4'h0)) begin
        failures++; $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, obs(), expv(4'h0));
      end
    end
    jogada_feita = 1'b0;
  endtask

  // Any state that accepts iniciar -> preparacao (one cycle) -> espera_jogada.
  task automatic test_start(input string tag);
    iniciar = 1'b1;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h1)) begin
      failures++; $display("FAIL %s_prep got=%h want=%h", tag, obs(), expv(4'h1));
    end
    iniciar = 1'b0;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h2)) begin
      failures++; $display("FAIL %s_wait got=%h want=%h", tag, obs(), expv(4'h2));
    end
  endtask

  // Plays a round from espera_jogada. err_pos in 1..16 is the missed play, 17 means none.
  task automatic play_round(input int err_pos, input bit noisy, input string tag);
    int base_r, base_c, exp_r, gap;
    logic [3:0] end_code;
    base_r = reg_cnt;
    base_c = conta_cnt;
    for (int k = 1; k <= 16; k++) begin
      gap = noisy ? int'($urandom_range(0, 5)) : 0;
      for (int g = 0; g < gap; g++) begin
        jogada_feita = 1'b0;
        iniciar = 1'($urandom); igual = 1'($urandom); fimC = 1'($urandom);
        @(negedge clock);
        checks++;
        if (obs() !== expv(4'h2)) begin
          failures++; $display("FAIL %s_gap play=%0d got=%h want=%h", tag, k, obs(), expv(4'h2));
        end
      end
      jogada_feita = 1'b1;
      igual = (k != err_pos);
      fimC = (k == 16);
      iniciar = noisy ? 1'($urandom) : 1'b0;
      @(negedge clock);
      checks++;
      if (obs() !== expv(4'h4)) begin
        failures++; $display("FAIL %s_reg play=%0d got=%h want=%h", tag, k, obs(), expv(4'h4));
      end
      jogada_feita = noisy ? 1'($urandom) : 1'b0;
      @(negedge clock);
      checks++;
      if (obs() !== expv(4'h5)) begin
        failures++; $display("FAIL %s_cmp play=%0d got=%h want=%h", tag, k, obs(), expv(4'h5));
      end
      iniciar = 1'b0;
      jogada_feita = noisy ? 1'($urandom) : 1'b0;
      @(negedge clock);
      if (k == err_pos || k == 16) begin
        end_code = (k == err_pos) ? 4'hE : 4'hA;
        checks++;
        if (obs() !== expv(end_code)) begin
          failures++; $display("FAIL %s_end play=%0d got=%h want=%h", tag, k, obs(), expv(end_code));
        end
        break;
      end
      checks++;
      if (obs() !== expv(4'h6)) begin
        failures++; $display("FAIL %s_next play=%0d got=%h want=%h", tag, k, obs(), expv(4'h6));
      end
      jogada_feita = 1'b0;
      @(negedge clock);
      checks++;
      if (obs() !== expv(4'h2)) begin
        failures++; $display("FAIL %s_back play=%0d got=%h want=%h", tag, k, obs(), expv(4'h2));
      end
    end
    jogada_feita = 1'b0;
    iniciar = 1'b0;
    end_code = (err_pos <= 16) ? 4'hE : 4'hA;
    repeat (3) @(negedge clock);
    checks++;
    if (obs() !== expv(end_code)) begin
      failures++; $display("FAIL %s_end_hold got=%h want=%h", tag, obs(), expv(end_code));
    end
    exp_r = (err_pos <= 16) ? err_pos : 16;
    checks++;
    if (reg_cnt - base_r !== exp_r) begin
      failures++; $display("FAIL %s_registraR_count got=%0d want=%0d", tag, reg_cnt - base_r, exp_r);
    end
    checks++;
    if (conta_cnt - base_c !== exp_r - 1) begin
      failures++;
      $display("FAIL %s_contaC_count got=%0d want=%0d", tag, conta_cnt - base_c, exp_r - 1);
    end
  endtask

  task automatic test_full_round();
    play_round(17, 1'b0, "full");
  endtask

  task automatic test_miss_third();
    test_start("miss");
    play_round(3, 1'b0, "miss3");
    test_start("after_miss");
  endtask

  task automatic test_random_rounds();
    int err;
    for (int r = 0; r < 6; r++) begin
      err = ($urandom_range(0, 2) == 0) ? 17 : int'($urandom_range(1, 16));
      play_round(err, 1'b1, $sformatf("rnd%0d", r));
      test_start($sformatf("rnd%0d_restart", r));
    end
  endtask

  // Starts in espera_jogada at the negedge of its first cycle.
  task automatic test_timeout();
`ifdef EXP5_UC_TIMEOUT_EN
    jogada_feita = 1'b0;
    repeat (7) @(negedge clock);
    checks++;
    if (obs() !== expv(4'h2)) begin
      failures++; $display("FAIL to_cycle8 got=%h want=%h", obs(), expv(4'h2));
    end
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'hD)) begin
      failures++; $display("FAIL to_expire got=%h want=%h", obs(), expv(4'hD));
    end
    test_start("to_restart");
    repeat (7) @(negedge clock);
    jogada_feita = 1'b1;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h4)) begin
      failures++; $display("FAIL to_last_cycle_play got=%h want=%h", obs(), expv(4'h4));
    end
`else
    jogada_feita = 1'b0;
    repeat (30) @(negedge clock);
    checks++;
    if (obs() !== expv(4'h2)) begin
      failures++; $display("FAIL no_timeout_wait got=%h want=%h", obs(), expv(4'h2));
    end
    jogada_feita = 1'b1;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h4)) begin
      failures++; $display("FAIL late_play got=%h want=%h", obs(), expv(4'h4));
    end
`endif
    jogada_feita = 1'b0;
    igual = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs() !== expv(4'hE)) begin
      failures++; $display("FAIL to_miss got=%h want=%h", obs(), expv(4'hE));
    end
  endtask

  task automatic test_async_reset();
    test_start("ar");
    jogada_feita = 1'b1;
    igual = 1'b1;
    fimC = 1'b0;
    @(negedge clock);
    jogada_feita = 1'b0;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h5)) begin
      failures++; $display("FAIL ar_cmp got=%h want=%h", obs(), expv(4'h5));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== expv(4'h0)) begin
      failures++; $display("FAIL ar_async got=%h want=%h", obs(), expv(4'h0));
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (obs() !== expv(4'h0)) begin
      failures++; $display("FAIL ar_release got=%h want=%h", obs(), expv(4'h0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start("first");
    test_full_round();
    test_miss_third();
    test_random_rounds();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit for the Experiment 5 memory-game datapath (`exp5_fluxo_dados`).
- Consumes the datapath status signals `igual`, `fimC` and `jogada_feita`.
- Sequences the address counter and the play register through one full 16-position round.
- Reports the outcome (hit all / miss) to the top level.
- Sits directly between the top-level buttons and the datapath control inputs.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 5000: number of cycles allowed in `espera_jogada` before a timeout. Only used with `TIMEOUT_EN`.

Ports:
- `clock`, input, 1: single system clock; all state changes occur on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Low forces state `inicial` immediately.
- `iniciar`, input, 1: start request, sampled synchronously.
- `jogada_feita`, input, 1: one-cycle pulse from the datapath edge detector.
- `igual`, input, 1: memory data equals registered play.
- `fimC`, input, 1: address counter at last position (15).
- `zeraC`, output, 1: clear the address counter.
- `contaC`, output, 1: increment the address counter.
- `zeraR`, output, 1: clear the play register.
- `registraR`, output, 1: load the play register.
- `pronto`, output, 1: round finished (any end state).
- `acertou`, output, 1: round finished with all 16 plays correct.
- `errou`, output, 1: round finished on a wrong play.
- `timeout`, output, 1: round finished by timeout. Tied to 0 without `TIMEOUT_EN`.
- `db_estado`, output, 4: current state code, for the 7-segment debug display.

## Operation

- Pure Moore FSM: every output is a decode of the state register only.
- State codes: `inicial`=0x0, `preparacao`=0x1, `espera_jogada`=0x2, `registra`=0x4, `comparacao`=0x5, `proximo`=0x6, `fim_acertou`=0xA, `fim_errou`=0xE, `fim_timeout`=0xD.
- `db_estado` equals the state code.

State behaviour:
- `inicial`: all outputs 0.
  - `iniciar`=1 → `preparacao`; otherwise stay.
- `preparacao`: `zeraC`=1, `zeraR`=1.
  - Always → `espera_jogada`.
- `espera_jogada`: no outputs asserted.
  - `jogada_feita`=1 → `registra`; otherwise stay.
- `registra`: `registraR`=1.
  - Always → `comparacao`.
- `comparacao`: no outputs asserted.
  - `igual`=0 → `fim_errou`.
  - `igual`=1 and `fimC`=1 → `fim_acertou`.
  - `igual`=1 and `fimC`=0 → `proximo`.
- `proximo`: `contaC`=1.
  - Always → `espera_jogada`.
- End states (`fim_acertou`, `fim_errou`, `fim_timeout`):
  - `pronto`=1 and the matching result flag=1, held until the state is left.
  - `iniciar`=1 → `preparacao`; otherwise stay.
- Any unused state code → `inicial` on the next edge, with all outputs 0 while in it.
- `iniciar` is ignored in every non-end state except `inicial`.

## Timing

- Reset:
  - State = `inicial`.
  - All control and result outputs = 0, `db_estado`=0x0.
  - Timeout counter = 0.
- Reset asserted mid-round aborts the round immediately and asynchronously.
- First state after reset release: `inicial`.
- Output latency: outputs change one `clock` edge after the input condition that causes the transition is sampled.
- Per-play path: `espera_jogada` → `registra` → `comparacao` → `proximo`/end, i.e. 3 cycles after the `jogada_feita` pulse is sampled.
- `comparacao` is one full cycle after `registraR`. The register output and the ROM output (address stable since `proximo`) are both settled when `igual` is sampled.
- `jogada_feita` arriving outside `espera_jogada` is dropped; there is no queuing.
- Full round with no errors: exactly 16 `registraR` pulses and 15 `contaC` pulses. `fimC` is only evaluated in `comparacao`.

## Configuration

- Macro `EXP5_UC_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`) is cleared on every entry to `espera_jogada` and increments each cycle spent there.
  - Counter reaching `TIMEOUT_CYCLES`-1 with `jogada_feita`=0 → `fim_timeout` (`pronto`=1, `timeout`=1).
  - `jogada_feita`=1 in that same cycle wins and goes → `registra`.
- Not defined:
  - No counter is built and `fim_timeout` is unreachable.
  - `timeout` is constant 0.
  - `espera_jogada` waits indefinitely.

## Test plan

- Reset low at t=0, then high → `db_estado`=0x0, all outputs 0. Hold `iniciar`=0 for 10 cycles → stays 0x0.
- `iniciar` pulse → `zeraC`=`zeraR`=1 for exactly one cycle, then `db_estado`=0x2.
- 16 `jogada_feita` pulses with `igual`=1, `fimC`=1 on the 16th → 16 `registraR` pulses and 15 `contaC` pulses, ending at 0xA with `pronto`=1, `acertou`=1.
- 3rd play with `igual`=0 → `db_estado`=0xE, `errou`=1, `contaC` count=2. `iniciar` then → 0x1.
- With `EXP5_UC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: no play for 8 cycles in 0x2 → 0xD, `timeout`=1. Re-run with the pulse on the 8th cycle → 0x4.
- Reset low while in `comparacao` → 0x0 asynchronously, all outputs 0 before the next `clock` edge.
